// File: rtl/meas_clock_sched.sv
// Round-robin clock period/duty measurement scheduler: one shared cycle-counting engine
// time-multiplexed over NCH synchronized clock channels.
//   state    | meaning
//   S_IDLE   | no owner; arbitrate among requesting channels
//   S_SETTLE | mux switched, ignoring edges for SETTLE cycles
//   S_ARM    | waiting for the first rising edge (t0)
//   S_MEAS   | accumulating period/high counts over NAVG periods
//   S_DONE   | result held until consumer handshake
module meas_clock_sched #(
  parameter int NCH    = 4,
  parameter int CW     = 24,
  parameter int NAVG   = 8,
  parameter int SETTLE = 16,
  parameter int TMO    = 65535,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  pos_edge,
  input  logic [NCH-1:0]  neg_edge,
  output logic [CH_W-1:0] sel,
  output logic [NCH-1:0]  grant,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CH_W-1:0] res_ch,
  output logic [CW-1:0]   res_period,
  output logic [CW-1:0]   res_high,
  output logic            res_err
);

  localparam int ST_W = $clog2(SETTLE + 1);
  localparam int EW   = $clog2(NAVG + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ARM, S_MEAS, S_DONE} state_t;

  state_t          r_state;
  logic [CH_W-1:0] r_sel, r_ptr, r_res_ch;
  logic [NCH-1:0]  r_grant;
  logic            r_busy, r_valid, r_res_err, r_hflag;
  logic [ST_W-1:0] r_stl;
  logic [CW-1:0]   r_wd, r_per, r_high, r_res_per, r_res_high;
  logic [EW-1:0]   r_edge;

  logic [CH_W-1:0] w_cand [NCH];
  logic [CH_W-1:0] w_pick;
  logic            w_found, w_pos, w_neg;
  logic [CW-1:0]   w_per_nxt, w_high_nxt;

  // Candidate order: the channel after the pointer first, the pointer itself last.
  for (genvar g = 0; g < NCH; g++) begin : g_cand
    assign w_cand[g] = CH_W'((int'(r_ptr) + g + 1) % NCH);
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && req[w_cand[i]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[i];
      end
    end
  end

  assign w_pos      = pos_edge[r_sel];
  assign w_neg      = neg_edge[r_sel];
  assign w_per_nxt  = (&r_per) ? r_per : r_per + 1'b1;
  assign w_high_nxt = (r_hflag && !(&r_high)) ? r_high + 1'b1 : r_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_ptr      <= CH_W'(NCH - 1);
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_res_ch   <= '0;
      r_res_per  <= '0;
      r_res_high <= '0;
      r_res_err  <= 1'b0;
      r_hflag    <= 1'b0;
      r_stl      <= '0;
      r_wd       <= '0;
      r_per      <= '0;
      r_high     <= '0;
      r_edge     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sel   <= w_pick;
            r_grant <= NCH'(1) << w_pick;
            r_busy  <= 1'b1;
            r_stl   <= ST_W'(SETTLE);
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_stl <= ST_W'(1)) begin
            r_wd    <= CW'(TMO);
            r_state <= S_ARM;
          end else begin
            r_stl <= r_stl - 1'b1;
          end
        end
        S_ARM: begin
          if (w_pos) begin
            r_per   <= '0;
            r_high  <= '0;
            r_edge  <= '0;
            r_hflag <= 1'b1;
            r_wd    <= CW'(TMO);
            r_state <= S_MEAS;
          end else if (r_wd <= CW'(1)) begin
            r_res_ch   <= r_sel;
            r_res_per  <= '0;
            r_res_high <= '0;
            r_res_err  <= 1'b1;
            r_valid    <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_wd <= r_wd - 1'b1;
          end
        end
        S_MEAS: begin
          r_per  <= w_per_nxt;
          r_high <= w_high_nxt;
          // A rising edge wins over a coincident falling edge.
          if (w_pos) begin
            r_hflag <= 1'b1;
            r_edge  <= r_edge + 1'b1;
            r_wd    <= CW'(TMO);
            if (r_edge == EW'(NAVG - 1)) begin
              r_res_ch   <= r_sel;
              r_res_per  <= w_per_nxt;
              r_res_high <= w_high_nxt;
              r_res_err  <= 1'b0;
              r_valid    <= 1'b1;
              r_state    <= S_DONE;
            end
          end else begin
            if (w_neg) r_hflag <= 1'b0;
            if (r_wd <= CW'(1)) begin
              r_res_ch   <= r_sel;
              r_res_per  <= w_per_nxt;
              r_res_high <= w_high_nxt;
              r_res_err  <= 1'b1;
              r_valid    <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_wd <= r_wd - 1'b1;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_ptr   <= r_res_ch;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel        = r_sel;
  assign grant      = r_grant;
  assign busy       = r_busy;
  assign res_valid  = r_valid;
  assign res_ch     = r_res_ch;
  assign res_period = r_res_per;
  assign res_high   = r_res_high;
  assign res_err    = r_res_err;

endmodule

// File: tb/tb_meas_clock_sched.sv
// Scoreboard bench for meas_clock_sched: directed scenarios push expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_meas_clock_sched;
  localparam int NCH = 4, CW = 24, NAVG = 8, SETTLE = 16, TMO = 100;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] pos_edge = '0;
  logic [NCH-1:0] neg_edge = '0;
  logic           res_ready = 1'b1;
  logic [1:0]     sel, res_ch;
  logic [NCH-1:0] grant;
  logic           busy, res_valid, res_err;
  logic [CW-1:0]  res_period, res_high;

  meas_clock_sched #(.NCH(NCH), .CW(CW), .NAVG(NAVG), .SETTLE(SETTLE), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .pos_edge(pos_edge), .neg_edge(neg_edge),
    .sel(sel), .grant(grant), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_period(res_period), .res_high(res_high), .res_err(res_err));

  always #5 clk = ~clk;

  typedef struct {int ch; int per; int high; int err;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int total = 0, bad = 0;

  // Channel clocks: rising edge when cyc%per==0, falling edge when cyc%per==hi.
  int per_c[NCH] = '{10, 6, 12, 7};
  int hi_c[NCH]  = '{4, 3, 5, 2};
  logic [NCH-1:0] en = '0;
  int cyc = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      pos_edge[c] = en[c] && (cyc % per_c[c] == 0);
      neg_edge[c] = en[c] && (cyc % per_c[c] == hi_c[c]);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tfail(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        tfail("unexpected_result");
      end else begin
        mon_e = sb.pop_front();
        chk("res_ch", int'(res_ch), mon_e.ch);
        chk("res_period", int'(res_period), mon_e.per);
        chk("res_high", int'(res_high), mon_e.high);
        chk("res_err", int'(res_err), mon_e.err);
      end
    end
  end

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == '0 && n < 400);
    if (grant == '0) tfail("wait_grant");
  endtask

  task automatic wait_hs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(res_valid && res_ready) && n < 600);
    if (!(res_valid && res_ready)) tfail("wait_handshake");
  endtask

  task automatic push_ch(input int ch);
    sb.push_back('{ch, per_c[ch] * NAVG, hi_c[ch] * NAVG, 0});
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_sel"}, int'(sel), 0);
    chk({tag, "_valid"}, int'(res_valid), 0);
    chk({tag, "_res_ch"}, int'(res_ch), 0);
    chk({tag, "_res_period"}, int'(res_period), 0);
    chk({tag, "_res_high"}, int'(res_high), 0);
    chk({tag, "_res_err"}, int'(res_err), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, m, viol;
    int ord[5] = '{0, 1, 2, 3, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    drv_edge();
    rst = 1'b0;

    // Single channel, 10-cycle period, 4 cycles high.
    en = 4'b0001;
    req = 4'b0001;
    push_ch(0);
    wait_grant(n);
    chk("t1_grant", int'(grant), 1);
    chk("t1_sel", int'(sel), 0);
    chk("t1_busy", int'(busy), 1);
    drv_edge();
    req = '0;
    wait_hs();
    @(negedge clk);
    chk("t1_busy_after_hs", int'(busy), 0);

    // Foreign channels toggling while ch0 is measured.
    en = 4'b1011;
    req = 4'b0001;
    push_ch(0);
    wait_grant(n);
    chk("t5_sel", int'(sel), 0);
    drv_edge();
    req = '0;
    wait_hs();

    // Coincident rise/fall each period: rise wins, so high spans the whole window.
    drv_edge();
    hi_c[0] = 0;
    req = 4'b0001;
    sb.push_back('{0, 80, 80, 0});
    wait_grant(n);
    drv_edge();
    req = '0;
    wait_hs();
    drv_edge();
    hi_c[0] = 4;

    // Round robin from a fresh reset.
    rst = 1'b1;
    repeat (2) drv_edge();
    rst = 1'b0;
    en = 4'b1111;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_ch(ord[k]);
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      if (k > 0) chk("rr_gap", n, 2);
      chk("rr_sel", int'(sel), ord[k]);
      chk("rr_grant", int'(grant), 1 << ord[k]);
      if (k == 4) begin
        drv_edge();
        req = '0;
      end
      wait_hs();
    end

    // Watchdog abort in ARM: ch2 silent.
    en = 4'b1011;
    req = 4'b0100;
    sb.push_back('{2, 0, 0, 1});
    wait_grant(n);
    chk("t3_sel", int'(sel), 2);
    drv_edge();
    req = '0;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!res_valid && m < 400);
    chk("tmo_latency", m, SETTLE + TMO);

    // Backpressure on ch1 while every channel requests.
    drv_edge();
    en = 4'b1111;
    res_ready = 1'b0;
    req = 4'b0010;
    push_ch(1);
    wait_grant(n);
    chk("t4_sel", int'(sel), 1);
    drv_edge();
    req = 4'b1111;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!res_valid && m < 600);
    if (!res_valid) tfail("t4_wait_valid");
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (!res_valid || res_ch != 2'd1 || res_period != 24'd48 || res_high != 24'd24 ||
          res_err || grant != 4'b0010 || !busy) viol++;
    end
    chk("bp_stable", viol, 0);
    drv_edge();
    res_ready = 1'b1;
    wait_hs();
    wait_grant(n);
    chk("bp_next_gap", n, 2);
    chk("bp_next_sel", int'(sel), 2);

    // Reset in the middle of ch2's measurement.
    repeat (40) @(negedge clk);
    drv_edge();
    rst = 1'b1;
    drv_edge();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("midrst");
    wait_grant(n);
    chk("midrst_regrant_lat", n, 1);
    chk("midrst_regrant_sel", int'(sel), 0);
    push_ch(0);
    drv_edge();
    req = '0;
    wait_hs();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/meas_clock_sched.md
Name: meas_clock_sched

Overview:
Time-shared clock measurement scheduler. It arbitrates one cycle-counting period/duty measurement engine round-robin among NCH clock channels, and sequences each measurement as mux select, settle, arm on a rising edge, accumulate over NAVG periods, then report. It sits between per-channel clock edge detectors (synchronized single-cycle pulses) and the digital consumer of frequency and duty-cycle results, which derives frequency as NAVG/res_period and duty as res_high/res_period.

Parameters:
NCH, 4, number of measured clock channels (>=2)
CW, 24, width of the cycle counters and result fields
NAVG, 8, rising-edge periods accumulated per measurement (>=1)
SETTLE, 16, cycles to wait after a select change before arming
TMO, 65535, watchdog cycles without a selected rising edge before abort (< 2^CW)
CH_W, max(1,$clog2(NCH)), channel index width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NCH  per-channel measurement request level
pos_edge  in  NCH  one-cycle pulse per rising edge of channel clock, already synchronized to clk
neg_edge  in  NCH  one-cycle pulse per falling edge of channel clock, already synchronized to clk
sel  out  CH_W  channel currently owning the engine
grant  out  NCH  one-hot grant, all zero when idle
busy  out  1  high in every state except IDLE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_ch  out  CH_W  channel of the result
res_period  out  CW  total clk cycles over NAVG periods
res_high  out  CW  total clk cycles the channel clock was high within those periods
res_err  out  1  measurement aborted by watchdog

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, sel=0, grant=0, busy=0, res_valid=0, res_ch=0, res_period=0, res_high=0, res_err=0, round-robin pointer=NCH-1, so ch0 has priority first. rst asserted in any state aborts the measurement with no result.
- States: IDLE -> SETTLE -> ARM -> MEAS -> DONE -> IDLE. ARM or MEAS -> DONE on timeout.
- IDLE: if req!=0, grant the first requesting channel after the pointer, circularly. At the next edge: sel and grant update, settle counter loads SETTLE, state=SETTLE. If req==0, stay in IDLE.
- SETTLE: all edge pulses are ignored. After exactly SETTLE cycles in SETTLE, go to ARM and clear the watchdog.
- ARM: wait for pos_edge[sel]. On that cycle (t0), clear per_cnt, high_cnt and edge_cnt, set high_flag=1, clear the watchdog, and go to MEAS.
- MEAS, each cycle after t0:
  - per_cnt += 1.
  - high_cnt += 1 if high_flag was 1 at the start of the cycle.
  - Both counters saturate at 2^CW-1.
  - neg_edge[sel] clears high_flag. pos_edge[sel] sets high_flag, increments edge_cnt and clears the watchdog. If pos and neg occur in the same cycle, pos wins and high_flag=1.
  - When edge_cnt reaches NAVG, go to DONE. This gives res_period = tN - t0 and res_high = sum over periods of (t_neg - t_pos).
- Watchdog (ARM and MEAS): counts cycles since ARM entry or since the last pos_edge[sel]. On reaching TMO, go to DONE with res_err=1. Results are the partial counts; both are 0 if the abort happens in ARM.
- Edge pulses on non-selected channels are ignored in all states.
- req is sampled only in IDLE. Deasserting it mid-measurement does not abort; the result is still delivered.
- DONE: res_valid=1. res_ch, res_period, res_high and res_err are registered on DONE entry and held stable until the handshake.
  - Handshake completes on the first cycle with res_valid & res_ready, including the DONE entry cycle.
  - After the handshake: state=IDLE, grant=0, pointer=res_ch, res_valid=0. Result fields hold their values.
  - At least one IDLE cycle occurs between grants.
- busy=1 from the cycle grant asserts until the cycle after the handshake.

Test Plan:
1. NAVG=8, SETTLE=16; req=0001; ch0 pos_edge every 10 cycles, neg_edge 4 cycles after each pos -> res_ch=0, res_period=80, res_high=32, res_err=0. The grant sequence is sel=0 then SETTLE, ARM, MEAS, DONE.
2. req=1111 held, res_ready=1, all channels toggling -> grants in order ch0, ch1, ch2, ch3, ch0; each grant is one-hot; exactly one IDLE cycle between consecutive results.
3. TMO=100; req=0100 with no edges on ch2 -> DONE exactly 100 cycles after ARM entry; res_err=1, res_period=0, res_high=0, res_ch=2.
4. Backpressure: res_ready=0 for 50 cycles in DONE while other channels request -> res_valid stays 1, result fields stable, grant stays on the current channel, no new arbitration until res_ready=1.
5. Edges on ch0 during SETTLE, and edges on ch1/ch3 while ch0 is measured -> result identical to scenario 1. A same-cycle pos+neg on ch0 leaves high_flag=1.
6. rst pulsed mid-MEAS on ch2 -> next cycle all outputs at reset values, no res_valid. With req=1111, the next grant is ch0.
